jtag_word_receiver: RTL and testbench
=====================================

Name: jtag_word_receiver

Overview:
- TDI-side counterpart of the TDO word transmitter: shifts a WIDTH-bit word in from TDI, one bit per TCK, while the TAP is in Shift-DR (enable high).
- Bits arrive MSB-first, the same order the transmitter emits them, so the first bit received lands in data[WIDTH-1].
- Presents the completed word in a holding register with a one-cycle valid pulse, for use by the instruction/data register logic behind the TAP controller.

Parameters:
- WIDTH, 32, word length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), derived localparam (not overridable); width of the bit counter.

Ports:
- clk_tck  input  1  JTAG TCK. All state updates on posedge, when TDI is stable.
- reset  input  1  asynchronous, active-high; clears all state immediately, no clock edge required.
- enable  input  1  high while in Shift-DR; each posedge with enable=1 consumes one TDI bit.
- tdi  input  1  serial data in.
- data  output  WIDTH  last completed word; changes only on completion.
- count  output  CNT_W  bits captured in the current word, 0..WIDTH.
- valid  output  1  one-cycle pulse on the posedge that captures the WIDTH-th bit.
- busy  output  1  high in SHIFT state.
- done  output  1  high in DONE state.
- overflow  output  1  present only with JTAG_RX_OVERFLOW_EN.

Behaviour:
- Reset values: data=0, count=0, valid=0, busy=0, done=0, overflow=0, internal shift register=0, state=IDLE.
- Shift register update: shreg <= {shreg[WIDTH-2:0], tdi}. Only the first WIDTH bits of a burst enter it.
- State machine: states IDLE, SHIFT, DONE; one transition per posedge.
- IDLE, enable=0: stay; count=0.
- IDLE, enable=1: capture bit; count=1; go to SHIFT.
- SHIFT, enable=1, count<WIDTH-1: capture bit; count+1.
- SHIFT, enable=1, count==WIDTH-1: capture the final bit. On the same edge: data <= {shreg[WIDTH-2:0], tdi}, count=WIDTH, valid=1, go to DONE.
- SHIFT, enable=0 (abort, early Exit1-DR): go to IDLE; count=0; data holds its previous value; no valid pulse.
- DONE, enable=1: extra TDI bits ignored; data and count unchanged; valid=0 after its one cycle.
- DONE, enable=0: go to IDLE; count=0; done=0.
- Latency: data and valid update on the same edge that samples the last bit. Outputs are registered; no combinational path from tdi.
- Back-to-back words: a new word needs enable to drop for at least one posedge (pass through IDLE). A continuous burst longer than WIDTH yields exactly one word.
- Asynchronous reset mid-shift: partial word discarded; data=0.
- valid never lasts more than one cycle and never asserts on an aborted word.
- count arithmetic is unsigned CNT_W bits and never exceeds WIDTH; no wrap-around.

Optional Feature:
- Macro: JTAG_RX_OVERFLOW_EN.
- Defined: overflow port exists.
  - Set on any posedge in DONE with enable=1, i.e. the host shifted more than WIDTH bits.
  - Sticky until the DONE->IDLE transition or reset.
  - data is unaffected.
- Undefined: overflow port and logic absent; extra bits are silently ignored.

Decomposition:
- Package jtag_rx_pkg:
  - rx_state_t enum {RX_IDLE, RX_SHIFT, RX_DONE}, 2 bits.
  - DEFAULT_WIDTH=32.
  - The transmitter may import DEFAULT_WIDTH later.
- No sub-module: the counter and shift register are small and share the FSM's enables, so the block stays flat.

Test Plan:
- Reset, then enable=1 for 32 posedges with TDI = 0xDEADBEEF MSB-first -> valid pulses once on edge 32; data=0xDEADBEEF; count=32; done=1; busy=0.
- Enable=1 for 10 bits, then enable=0 -> count returns to 0, state IDLE, no valid, data keeps its prior value (0xDEADBEEF).
- Assert reset asynchronously between edges 17 and 18 of a shift -> data, count, busy, done, valid all 0 before the next posedge; a fresh 32-bit shift of 0x12345678 then completes correctly.
- Two words 0x12345678 and 0x0000FFFF separated by one enable=0 cycle -> exactly two valid pulses, carrying those values in order.
- 35-bit burst whose first 32 bits are 0xA5A5A5A5 -> data=0xA5A5A5A5 and a single valid pulse. With JTAG_RX_OVERFLOW_EN, overflow=1 from edge 33 until enable drops, then 0.
- WIDTH=8 instance, shift 0x81 -> valid on edge 8, data=0x81, count=8.

Source files
------------

// File: rtl/jtag_rx_pkg.sv
// Shared types and defaults for the JTAG TDI word receiver (and later the TDO transmitter).
package jtag_rx_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_SHIFT = 2'd1,
      RX_DONE  = 2'd2
   } rx_state_t;

   localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/jtag_word_receiver_if.sv
// Shift-DR handshake and word outputs of the TDI receiver.
// The overflow signal exists only when JTAG_RX_OVERFLOW_EN is defined.
interface jtag_word_receiver_if
   import jtag_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             enable;
   logic             tdi;
   logic [WIDTH-1:0] data;
   logic [CNT_W-1:0] count;
   logic             valid;
   logic             busy;
   logic             done;
`ifdef JTAG_RX_OVERFLOW_EN
   logic             overflow;
`endif

   modport master (
      output enable, tdi,
      input  data, count, valid, busy, done
`ifdef JTAG_RX_OVERFLOW_EN
      , overflow
`endif
   );

   modport slave (
      input  enable, tdi,
      output data, count, valid, busy, done
`ifdef JTAG_RX_OVERFLOW_EN
      , overflow
`endif
   );

endinterface

// File: rtl/jtag_word_receiver.sv
// Shifts a WIDTH-bit word in from TDI MSB-first during Shift-DR and latches it with a valid pulse.
// Optional JTAG_RX_OVERFLOW_EN adds a sticky flag for bits shifted past WIDTH.
//
// state    | meaning
// RX_IDLE  | waiting for Shift-DR; count held at 0
// RX_SHIFT | capturing bits, count = bits taken so far
// RX_DONE  | word latched; further TDI bits ignored until enable drops
module jtag_word_receiver
   import jtag_rx_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk_tck,
   input  logic                 reset,
   jtag_word_receiver_if.slave  rx
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   rx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] shifted;
`ifdef JTAG_RX_OVERFLOW_EN
   logic             ovf_q, ovf_d;
`endif

   assign shifted = {shreg_q[WIDTH-2:0], rx.tdi};

   always_ff @(posedge clk_tck or posedge reset) begin
      if (reset) begin
         state_q <= RX_IDLE;
         shreg_q <= '0;
         data_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
`ifdef JTAG_RX_OVERFLOW_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         count_q <= count_d;
         valid_q <= valid_d;
`ifdef JTAG_RX_OVERFLOW_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      count_d = count_q;
      valid_d = 1'b0;
`ifdef JTAG_RX_OVERFLOW_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         RX_IDLE: begin
            count_d = '0;
            if (rx.enable) begin
               shreg_d = shifted;
               count_d = CNT_W'(1);
               state_d = RX_SHIFT;
            end
         end
         RX_SHIFT: begin
            if (!rx.enable) begin
               // Early Exit1-DR: drop the partial word, keep the last good one.
               count_d = '0;
               state_d = RX_IDLE;
            end else if (count_q == CNT_W'(WIDTH - 1)) begin
               shreg_d = shifted;
               data_d  = shifted;
               count_d = CNT_W'(WIDTH);
               valid_d = 1'b1;
               state_d = RX_DONE;
            end else begin
               shreg_d = shifted;
               count_d = count_q + CNT_W'(1);
            end
         end
         RX_DONE: begin
            if (!rx.enable) begin
               count_d = '0;
               state_d = RX_IDLE;
`ifdef JTAG_RX_OVERFLOW_EN
               ovf_d   = 1'b0;
`endif
            end else begin
`ifdef JTAG_RX_OVERFLOW_EN
               ovf_d   = 1'b1;
`endif
            end
         end
         default: begin
            count_d = '0;
            state_d = RX_IDLE;
         end
      endcase
   end

   assign rx.data  = data_q;
   assign rx.count = count_q;
   assign rx.valid = valid_q;
   assign rx.busy  = (state_q == RX_SHIFT);
   assign rx.done  = (state_q == RX_DONE);
`ifdef JTAG_RX_OVERFLOW_EN
   assign rx.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_jtag_word_receiver.sv
// Scoreboard bench for jtag_word_receiver: 32-bit and 8-bit instances on a shared TCK.
// Overflow checks are compiled in when JTAG_RX_OVERFLOW_EN is defined.
module tb_jtag_word_receiver;
   import jtag_rx_pkg::*;

   logic clk_tck = 1'b0;
   logic reset;
   always #5 clk_tck = ~clk_tck;

   jtag_word_receiver_if #(.WIDTH(32)) if32 ();
   jtag_word_receiver_if #(.WIDTH(8))  if8 ();

   jtag_word_receiver #(.WIDTH(32)) dut32 (.clk_tck(clk_tck), .reset(reset), .rx(if32.slave));
   jtag_word_receiver #(.WIDTH(8))  dut8  (.clk_tck(clk_tck), .reset(reset), .rx(if8.slave));

   int tests_run = 0;
   int tests_failed = 0;
   logic [63:0] sb32[$];
   logic [63:0] sb8[$];
   int nvalid32 = 0;
   int nvalid8 = 0;
   logic pv32 = 1'b0;
   logic pv8 = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Word monitors: every valid pulse must match the oldest pending expectation.
   always @(posedge clk_tck) begin
      #1;
      if (if32.valid === 1'b1) begin
         nvalid32++;
         chk("v32_one_cycle", 64'(pv32), 64'd0);
         chk("sb32_pending", 64'(sb32.size() != 0), 64'd1);
         if (sb32.size() != 0) chk("sb32_data", 64'(if32.data), sb32.pop_front());
      end
      if (if8.valid === 1'b1) begin
         nvalid8++;
         chk("v8_one_cycle", 64'(pv8), 64'd0);
         chk("sb8_pending", 64'(sb8.size() != 0), 64'd1);
         if (sb8.size() != 0) chk("sb8_data", 64'(if8.data), sb8.pop_front());
      end
      pv32 = if32.valid;
      pv8  = if8.valid;
   end

   task automatic step(input logic en, input logic b, input bit w8 = 1'b0);
      @(negedge clk_tck);
      if (w8) begin
         if8.enable  = en;
         if8.tdi     = b;
         if32.enable = 1'b0;
      end else begin
         if32.enable = en;
         if32.tdi    = b;
         if8.enable  = 1'b0;
      end
      @(posedge clk_tck);
      #2;
   endtask

   // Drive n enabled bits MSB-first; bits past the word width are all ones.
   task automatic shift_bits(input logic [63:0] w, input int width, input int n, input bit w8 = 1'b0);
      for (int i = 0; i < n; i++) begin
         step(1'b1, (i < width) ? w[width-1-i] : 1'b1, w8);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] d, input int cnt,
                        input logic v, input logic b, input logic dn);
      chk({tag, "_data"},  64'(if32.data),  64'(d));
      chk({tag, "_count"}, 64'(if32.count), 64'(cnt));
      chk({tag, "_valid"}, 64'(if32.valid), 64'(v));
      chk({tag, "_busy"},  64'(if32.busy),  64'(b));
      chk({tag, "_done"},  64'(if32.done),  64'(dn));
   endtask

   int n0;

   initial begin
      reset       = 1'b1;
      if32.enable = 1'b0;
      if32.tdi    = 1'b0;
      if8.enable  = 1'b0;
      if8.tdi     = 1'b0;
      #12;
      chk32("rst", 32'h0, 0, 1'b0, 1'b0, 1'b0);
`ifdef JTAG_RX_OVERFLOW_EN
      chk("rst_ovf", 64'(if32.overflow), 64'd0);
`endif
      @(negedge clk_tck);
      reset = 1'b0;

      // Full word, checking the valid edge exactly.
      n0 = nvalid32;
      sb32.push_back(64'hDEADBEEF);
      shift_bits(64'hDEADBEEF, 32, 31);
      chk32("t1_e31", 32'h0, 31, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk32("t1_e32", 32'hDEADBEEF, 32, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk32("t1_idle", 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
      chk("t1_pulses", 64'(nvalid32 - n0), 64'd1);

      // Abort after 10 bits.
      n0 = nvalid32;
      shift_bits(64'h2AB, 10, 10);
      chk32("t2_mid", 32'hDEADBEEF, 10, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk32("t2_abort", 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
      chk("t2_pulses", 64'(nvalid32 - n0), 64'd0);

      // Async reset between edges 17 and 18.
      shift_bits(64'hCAFEF00D, 32, 17);
      #1 reset = 1'b1;
      #1;
      chk32("t3_rst", 32'h0, 0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b0, 1'b0);
      sb32.push_back(64'h12345678);
      shift_bits(64'h12345678, 32, 32);
      chk32("t3_word", 32'h12345678, 32, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Back-to-back words with a single idle cycle.
      n0 = nvalid32;
      sb32.push_back(64'h12345678);
      sb32.push_back(64'h0000FFFF);
      shift_bits(64'h12345678, 32, 32);
      step(1'b0, 1'b0);
      shift_bits(64'h0000FFFF, 32, 32);
      chk32("t4_w2", 32'h0000FFFF, 32, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("t4_pulses", 64'(nvalid32 - n0), 64'd2);

      // 35-bit burst: extra bits ignored.
      n0 = nvalid32;
      sb32.push_back(64'hA5A5A5A5);
      shift_bits(64'hA5A5A5A5, 32, 32);
`ifdef JTAG_RX_OVERFLOW_EN
      chk("t5_ovf_e32", 64'(if32.overflow), 64'd0);
`endif
      for (int k = 0; k < 3; k++) begin
         step(1'b1, k[0]);
         chk32("t5_extra", 32'hA5A5A5A5, 32, 1'b0, 1'b0, 1'b1);
`ifdef JTAG_RX_OVERFLOW_EN
         chk("t5_ovf_set", 64'(if32.overflow), 64'd1);
`endif
      end
      step(1'b0, 1'b0);
      chk32("t5_idle", 32'hA5A5A5A5, 0, 1'b0, 1'b0, 1'b0);
`ifdef JTAG_RX_OVERFLOW_EN
      chk("t5_ovf_clr", 64'(if32.overflow), 64'd0);
`endif
      chk("t5_pulses", 64'(nvalid32 - n0), 64'd1);

      // WIDTH=8 instance.
      n0 = nvalid32;
      sb8.push_back(64'h81);
      shift_bits(64'h81, 8, 7, 1'b1);
      chk("t6_e7_valid", 64'(if8.valid), 64'd0);
      chk("t6_e7_count", 64'(if8.count), 64'd7);
      step(1'b1, 1'b1, 1'b1);
      chk("t6_e8_valid", 64'(if8.valid), 64'd1);
      chk("t6_e8_data",  64'(if8.data),  64'h81);
      chk("t6_e8_count", 64'(if8.count), 64'd8);
      chk("t6_e8_done",  64'(if8.done),  64'd1);
      step(1'b0, 1'b0, 1'b1);
      chk("t6_idle_count", 64'(if8.count), 64'd0);
      chk("t6_w32_quiet", 64'(nvalid32 - n0), 64'd0);

      chk("sb32_drained", 64'(sb32.size()), 64'd0);
      chk("sb8_drained",  64'(sb8.size()),  64'd0);
      chk("nvalid8",      64'(nvalid8),     64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
